// File: rtl/uart_rx_fifo.sv
// Receive FIFO that buffers UART characters with a break tag, in first-word-fall-through order.
// Latency: a push into an empty FIFO is visible on rd_valid/rd_data right after the write edge.
// Backpressure: rd_ready stalls the head entry; a push while full with no pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, resetn                  single clock, asynchronous active-low reset
//   uart_rx_valid/_data/_break   one-cycle character strobe, payload and break tag
//   rd_valid/rd_ready            head handshake; rd_data/rd_break show the head entry
//   count, full                  occupancy (0..DEPTH) and count==DEPTH
//   overflow, ovf_clear          sticky drop flag and its clear (a drop in the same cycle wins)
//
// Optional feature: define UART_RX_FIFO_BREAK_FLUSH_EN to make an incoming break
// discard all stored entries and become the only entry.

module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      uart_rx_valid,
    input  logic [PAYLOAD_BITS-1:0]   uart_rx_data,
    input  logic                      uart_rx_break,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [PAYLOAD_BITS-1:0]   rd_data,
    output logic                      rd_break,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    input  logic                      ovf_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = PAYLOAD_BITS + 1;

    // Storage is deliberately not reset; the head is masked while empty instead.
    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          pop;
    logic          push;
    logic          drop;
    logic          flush;
    logic          wr_en;
    logic [EW-1:0] head;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;

    assign head     = mem_q[rd_ptr_q];
    assign rd_data  = rd_valid ? head[PAYLOAD_BITS-1:0] : '0;
    assign rd_break = rd_valid ? head[EW-1] : 1'b0;

    assign pop = rd_valid & rd_ready;

`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    assign flush = uart_rx_valid & uart_rx_break;
`else
    assign flush = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = uart_rx_valid & (~full | pop) & ~flush;
    assign drop = uart_rx_valid & full & ~pop & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_en    = 1'b0;

        if (flush) begin
            // Write the break at the current write slot and make it the sole
            // entry by moving the read pointer onto it; any pop is overridden.
            wr_en    = 1'b1;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = CW'(1);
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {uart_rx_break, uart_rx_data};
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int PB    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          uart_rx_valid;
    logic [PB-1:0] uart_rx_data;
    logic          uart_rx_break;
    logic          rd_valid;
    logic          rd_ready;
    logic [PB-1:0] rd_data;
    logic          rd_break;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          ovf_clear;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: an ordered queue of {break, data} entries plus a sticky flag.
    logic [PB:0] mq[$];
    logic        m_ovf;

    uart_rx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_break (uart_rx_break),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_break      (rd_break),
        .count         (count),
        .full          (full),
        .overflow      (overflow),
        .ovf_clear     (ovf_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [PB:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk({tag, ".count"},    32'(count),    32'(mq.size()));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(h[PB-1:0]));
        chk({tag, ".rd_break"}, 32'(rd_break), 32'(h[PB]));
        chk({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Applies one cycle of inputs, advances the model by the behavioural rules,
    // then checks the DUT one time unit after the edge.
    task automatic step(input string tag, input logic v, input logic [PB-1:0] d,
                        input logic b, input logic r, input logic c);
        logic pop_m;
        logic flush_m;
        logic was_full;
        uart_rx_valid = v;
        uart_rx_data  = d;
        uart_rx_break = b;
        rd_ready      = r;
        ovf_clear     = c;

        pop_m    = (mq.size() != 0) && r;
        was_full = (mq.size() == DEPTH);
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        flush_m  = v && b;
`else
        flush_m  = 1'b0;
`endif
        if (flush_m) begin
            mq.delete();
            mq.push_back({b, d});
            if (c) m_ovf = 1'b0;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (v && (!was_full || pop_m)) mq.push_back({b, d});
            if (v && was_full && !pop_m) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end

        @(posedge clk);
        #1;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        uart_rx_break = 1'b0;
        rd_ready      = 1'b0;
        ovf_clear     = 1'b0;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++) step(tag, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        resetn        = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        uart_rx_break = 1'b0;
        rd_ready      = 1'b0;
        ovf_clear     = 1'b0;
        m_ovf         = 1'b0;

        // Reset state
        #2;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check_all("post_reset");

        // Three characters, then read back in order
        step("w41", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        chk("fwft_first", 32'(rd_data), 32'h41);
        step("w42", 1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step("w43", 1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
        chk("three_count", 32'(count), 32'd3);
        step("r41", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("r42", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("r43", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("three_empty", 32'(rd_valid), 32'd0);
        step("rdy_empty", 1'b0, '0, 1'b0, 1'b1, 1'b0);

        // 17 pushes into 16 entries: last dropped, overflow sticky
        for (int i = 0; i < 17; i++) step("fill", 1'b1, PB'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ovf", 32'(overflow), 32'd1);
        step("ovf_hold", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        step("drop_and_clr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("set_wins", 32'(overflow), 32'd1);
        step("ovf_clr2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous push and pop
        step("full_pushpop", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        chk("pp_count16", 32'(count), 32'd16);
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        drain("drain_full");

        // Pointer wrap with count pinned near 1
        step("wrap_seed", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step("wrap", 1'b1, PB'(i * 7), 1'b0, 1'b1, 1'b0);
            chk("wrap_le2", 32'(count <= CW'(2)), 32'd1);
        end
        drain("drain_wrap");

        // Break after five entries
        for (int i = 0; i < 5; i++) step("five", 1'b1, PB'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        step("brk", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        chk("brk_count", 32'(count), 32'd1);
        chk("brk_tag", 32'(rd_break), 32'd1);
`else
        chk("brk_count", 32'(count), 32'd6);
`endif
        drain("drain_brk");

        // Randomised traffic, first biased toward filling, then toward draining
        for (int i = 0; i < 600; i++) begin
            logic v, b, r, c;
            logic [PB-1:0] d;
            v = ($urandom_range(0, 9) < 6);
            d = PB'($urandom);
            b = ($urandom_range(0, 9) == 0);
            r = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            step("rand", v, d, b, r, c);
        end
        drain("drain_rand");

        // Asynchronous reset between edges with four entries stored
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, PB'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_data", 32'(rd_data), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_arst");
        step("after_rst", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("after_rst_head", 32'(rd_data), 32'h3C);
        drain("drain_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
